// File: rtl/apb_completer_pkg.sv
// ----------------------------------------------------------------------------
// apb_completer_pkg
// Shared definitions for the APB completer: register addresses, the access
// FSM state type and the bit positions of the STATUS register.
// ----------------------------------------------------------------------------
package apb_completer_pkg;

   // Register map (byte addresses)
   localparam logic [7:0] AddrCtrl   = 8'h00;
   localparam logic [7:0] AddrStatus = 8'h01;
   localparam logic [7:0] AddrTxdata = 8'h02;
   localparam logic [7:0] AddrRxdata = 8'h03;

   // STATUS bit positions
   localparam int unsigned StatTxEmpty  = 0;
   localparam int unsigned StatTxFull   = 1;
   localparam int unsigned StatRxFull   = 2;
   localparam int unsigned StatOverrun  = 3;
   localparam int unsigned StatTxCntLsb = 4;
   localparam int unsigned StatTxCntMsb = 6;

   // Width of the wait-state counter (WAIT_STATES is limited to 0..7)
   localparam int unsigned WaitCntW = 3;

   typedef enum logic {
      StIdle   = 1'b0,
      StAccess = 1'b1
   } state_e;

endpackage

// File: rtl/apb_completer_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with occupancy count. Full/empty are evaluated on the
// current state, so a push into a full FIFO is dropped even if a pop happens
// in the same cycle.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_data   write request and data
//   i_pop            read request (head is discarded)
//   o_data           head entry (0 when empty)
//   o_full, o_empty  occupancy flags
//   o_count          number of stored entries, 0..DEPTH
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PtrW-1:0]  r_wr_ptr;
   logic [PtrW-1:0]  r_rd_ptr;
   logic [CntW-1:0]  r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CntW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
         if (w_do_push && !w_do_pop)      r_count <= r_count + CntW'(1);
         else if (w_do_pop && !w_do_push) r_count <= r_count - CntW'(1);
      end
   end

   // Storage needs no reset: it is only visible through o_data when non-empty.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/apb_completer.sv
// ----------------------------------------------------------------------------
// apb_completer
// APB completer with a small register file (CTRL, STATUS, TXDATA, RXDATA),
// programmable wait states, a TX FIFO feeding a valid/ready stream and a
// single-entry RX holding register fed by a strobe.
// Ports:
//   pclk, presetn                      clock, asynchronous active-low reset
//   psel, penable, pwrite, paddr,
//   pwdata                             APB requester side
//   prdata, pready, pslverr            APB completer responses
//   ctrl_out                           CTRL register value
//   tx_data, tx_valid, tx_ready        TX stream (pop on valid & ready)
//   rx_data, rx_valid                  RX byte strobe, no backpressure
// ----------------------------------------------------------------------------
module apb_completer
   import apb_completer_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic       pclk,
   input  logic       presetn,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [7:0] paddr,
   input  logic [7:0] pwdata,
   output logic [7:0] prdata,
   output logic       pready,
   output logic       pslverr,
   output logic [7:0] ctrl_out,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid
);

   localparam int unsigned        CntW     = $clog2(FIFO_DEPTH + 1);
   localparam logic [WaitCntW-1:0] WaitInit = WaitCntW'(WAIT_STATES);

   state_e              r_state;
   state_e              w_state_d;
   logic [WaitCntW-1:0] r_wait_cnt;
   logic [WaitCntW-1:0] w_wait_cnt_d;

   logic [7:0]          r_ctrl;
   logic [7:0]          r_rx_data;
   logic                r_rx_full;
   logic                r_overrun;

   logic                w_pready;
   logic                w_complete;
   logic                w_err;
   logic                w_commit;
   logic [7:0]          w_rd_val;
   logic [7:0]          w_status;

   logic                w_wr_ctrl;
   logic                w_wr_status;
   logic                w_tx_push;
   logic                w_tx_pop;
   logic                w_rx_read;
   logic                w_rx_capture;
   logic                w_overrun_evt;

   logic                w_tx_full;
   logic                w_tx_empty;
   logic [CntW-1:0]     w_tx_count;

   // ---------------------------------------------------------------------
   // Access FSM
   // ---------------------------------------------------------------------
   assign w_pready   = (r_state == StAccess) && (r_wait_cnt == '0);
   assign w_complete = psel && penable && w_pready;

   always_comb begin
      w_state_d    = r_state;
      w_wait_cnt_d = r_wait_cnt;
      unique case (r_state)
         StIdle: begin
            if (psel && !penable) begin
               w_state_d    = StAccess;
               w_wait_cnt_d = WaitInit;
            end
         end
         StAccess: begin
            // Dropping psel before completion abandons the transfer.
            if (!psel || w_complete) begin
               w_state_d    = StIdle;
               w_wait_cnt_d = '0;
            end else if (r_wait_cnt != '0) begin
               w_wait_cnt_d = r_wait_cnt - WaitCntW'(1);
            end
         end
         default: begin
            w_state_d    = StIdle;
            w_wait_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state    <= StIdle;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_d;
         r_wait_cnt <= w_wait_cnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // Address decode, error detection and read mux
   // ---------------------------------------------------------------------
   always_comb begin
      w_status                             = '0;
      w_status[StatTxEmpty]                = w_tx_empty;
      w_status[StatTxFull]                 = w_tx_full;
      w_status[StatRxFull]                 = r_rx_full;
      w_status[StatOverrun]                = r_overrun;
      w_status[StatTxCntMsb:StatTxCntLsb]  = 3'(w_tx_count);
   end

   always_comb begin
      w_err    = 1'b0;
      w_rd_val = '0;
      case (paddr)
         AddrCtrl:   w_rd_val = r_ctrl;
         AddrStatus: w_rd_val = w_status;
         AddrTxdata: w_err    = !pwrite || w_tx_full;
         AddrRxdata: begin
            w_err    = pwrite || !r_rx_full;
            w_rd_val = r_rx_data;
         end
         default:    w_err    = 1'b1;
      endcase
   end

   assign w_commit    = w_complete && !w_err;
   assign pready      = w_pready;
   assign pslverr     = w_complete && w_err;
   assign prdata      = (w_commit && !pwrite) ? w_rd_val : '0;

   assign w_wr_ctrl   = w_commit && pwrite && (paddr == AddrCtrl);
   assign w_wr_status = w_commit && pwrite && (paddr == AddrStatus);
   assign w_tx_push   = w_commit && pwrite && (paddr == AddrTxdata);
   assign w_rx_read   = w_commit && !pwrite && (paddr == AddrRxdata);

   // ---------------------------------------------------------------------
   // CTRL register
   // ---------------------------------------------------------------------
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_ctrl <= '0;
      end else if (w_wr_ctrl) begin
         r_ctrl <= pwdata;
      end
   end

   assign ctrl_out = r_ctrl;

   // ---------------------------------------------------------------------
   // RX holding register. A read that frees the slot in the same cycle as a
   // new strobe lets the new byte in without counting as an overrun.
   // ---------------------------------------------------------------------
   assign w_rx_capture  = rx_valid && (!r_rx_full || w_rx_read);
   assign w_overrun_evt = rx_valid && r_rx_full && !w_rx_read;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_rx_data <= '0;
         r_rx_full <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_rx_capture) begin
            r_rx_data <= rx_data;
            r_rx_full <= 1'b1;
         end else if (w_rx_read) begin
            r_rx_full <= 1'b0;
         end
         // A new overrun in the same cycle beats the W1C clear.
         if (w_overrun_evt) begin
            r_overrun <= 1'b1;
         end else if (w_wr_status && pwdata[StatOverrun]) begin
            r_overrun <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // TX FIFO
   // ---------------------------------------------------------------------
   assign tx_valid = !w_tx_empty;
   assign w_tx_pop = tx_valid && tx_ready;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .i_clk   (pclk),
      .i_rst_n (presetn),
      .i_push  (w_tx_push),
      .i_data  (pwdata),
      .i_pop   (w_tx_pop),
      .o_data  (tx_data),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_count (w_tx_count)
   );

endmodule

// File: tb/tb_apb_completer.sv
// ----------------------------------------------------------------------------
// tb_apb_completer
// Directed scenarios followed by a randomized run, all checked against a
// transaction-level model (CTRL value, TX byte queue, RX slot and overrun).
// ----------------------------------------------------------------------------
module tb_apb_completer;

   localparam int unsigned WS    = 1;
   localparam int unsigned DEPTH = 4;

   logic       pclk = 1'b0;
   logic       presetn, psel, penable, pwrite;
   logic [7:0] paddr, pwdata, prdata, ctrl_out, tx_data, rx_data;
   logic       pready, pslverr, tx_valid, tx_ready, rx_valid;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0] m_ctrl;
   logic [7:0] m_rx_byte;
   logic       m_rx_full;
   logic       m_overrun;
   logic [7:0] m_q[$];

   always #5 pclk = ~pclk;

   apb_completer #(
      .WAIT_STATES (WS),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .pclk     (pclk),
      .presetn  (presetn),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .prdata   (prdata),
      .pready   (pready),
      .pslverr  (pslverr),
      .ctrl_out (ctrl_out),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid)
   );

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_ctrl    = 8'h00;
      m_rx_byte = 8'h00;
      m_rx_full = 1'b0;
      m_overrun = 1'b0;
      m_q.delete();
   endtask

   function automatic logic [7:0] m_status();
      logic [2:0] cnt;
      cnt = 3'(m_q.size());
      return {1'b0, cnt, m_overrun, m_rx_full, m_q.size() == DEPTH, m_q.size() == 0};
   endfunction

   task automatic chk_outs(input string tag);
      chk8({tag, "_ctrl"}, ctrl_out, m_ctrl);
      chk1({tag, "_txv"}, tx_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk8({tag, "_txd"}, tx_data, m_q[0]);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk8({tag, "_prdata"}, prdata, 8'h00);
      chk1({tag, "_pready"}, pready, 1'b0);
      chk1({tag, "_pslverr"}, pslverr, 1'b0);
      chk8({tag, "_ctrl"}, ctrl_out, 8'h00);
      chk1({tag, "_txv"}, tx_valid, 1'b0);
      chk8({tag, "_txd"}, tx_data, 8'h00);
   endtask

   // One APB transfer. crx/ctx drive rx_valid/tx_ready in the completion cycle.
   task automatic xfer(input string tag, input logic wr, input logic [7:0] a,
                       input logic [7:0] d, input logic crx, input logic [7:0] rxb,
                       input logic ctx);
      logic       exp_err, rdclr, ov_evt, done, got_err;
      logic [7:0] val, exp_rd, got_rd;
      int         waits;
      chk_outs({tag, "_pre"});
      exp_err = (a > 8'd3) || (wr && a == 8'd3) || (!wr && a == 8'd2) ||
                (wr && a == 8'd2 && m_q.size() == DEPTH) ||
                (!wr && a == 8'd3 && !m_rx_full);
      case (a)
         8'd0:    val = m_ctrl;
         8'd1:    val = m_status();
         8'd3:    val = m_rx_byte;
         default: val = 8'h00;
      endcase
      exp_rd = (wr || exp_err) ? 8'h00 : val;

      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge pclk); #1;
      penable = 1'b1;
      waits = 0; done = 1'b0; got_rd = 8'h00; got_err = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         if (pready) begin
            got_rd = prdata; got_err = pslverr; done = 1'b1;
            rx_valid = crx; rx_data = rxb; tx_ready = ctx;
         end else begin
            chk1({tag, "_wait_slverr"}, pslverr, 1'b0);
            chk8({tag, "_wait_prdata"}, prdata, 8'h00);
            waits++;
         end
         @(posedge pclk); #1;
      end
      psel = 1'b0; penable = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
      chk1({tag, "_done"}, done, 1'b1);
      chk8({tag, "_waits"}, 8'(waits), 8'(WS));
      chk1({tag, "_slverr"}, got_err, exp_err);
      if (!wr) chk8({tag, "_rdata"}, got_rd, exp_rd);

      rdclr  = !wr && a == 8'd3 && !exp_err;
      ov_evt = crx && m_rx_full && !rdclr;
      if (ctx && m_q.size() != 0) void'(m_q.pop_front());
      if (wr && a == 8'd2 && !exp_err) m_q.push_back(d);
      if (crx && !ov_evt) begin
         m_rx_byte = rxb;
         m_rx_full = 1'b1;
      end else if (rdclr) begin
         m_rx_full = 1'b0;
      end
      if (ov_evt) m_overrun = 1'b1;
      else if (wr && a == 8'd1 && d[3]) m_overrun = 1'b0;
      if (wr && a == 8'd0) m_ctrl = d;
      chk_outs({tag, "_post"});
   endtask

   // Transfer abandoned during its first (not-ready) access cycle.
   task automatic abort_xfer(input string tag, input logic [7:0] a, input logic [7:0] d);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(posedge pclk); #1;
      penable = 1'b1;
      #1;
      chk1({tag, "_notready"}, pready, 1'b0);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      chk1({tag, "_idle_pready"}, pready, 1'b0);
      chk_outs(tag);
   endtask

   // Bus-idle cycle, optionally popping TX and/or strobing RX.
   task automatic idle_cycle(input string tag, input logic r, input logic v,
                             input logic [7:0] b);
      tx_ready = r; rx_valid = v; rx_data = b;
      #1;
      chk1({tag, "_pready"}, pready, 1'b0);
      chk1({tag, "_slverr"}, pslverr, 1'b0);
      chk8({tag, "_prdata"}, prdata, 8'h00);
      chk_outs(tag);
      if (r && m_q.size() != 0) void'(m_q.pop_front());
      if (v) begin
         if (m_rx_full) m_overrun = 1'b1;
         else begin
            m_rx_byte = b;
            m_rx_full = 1'b1;
         end
      end
      @(posedge pclk); #1;
      tx_ready = 1'b0; rx_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] a, d, b;
      logic       wr, crx, ctx;
      int         sel;

      presetn = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 8'h00; pwdata = 8'h00; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      m_reset();
      #2 presetn = 1'b0;
      #1 chk_reset_outs("rst");
      repeat (2) @(posedge pclk);
      #1 presetn = 1'b1;
      @(posedge pclk); #1;

      // CTRL write/read
      xfer("ctrl_wr", 1'b1, 8'h00, 8'h5A, 1'b0, 8'h00, 1'b0);
      xfer("ctrl_rd", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

      // Fill TX FIFO past capacity, then drain
      for (int i = 0; i < 5; i++)
         xfer("tx_fill", 1'b1, 8'h02, 8'h11 + 8'(i), 1'b0, 8'h00, 1'b0);
      xfer("stat_full", 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
      chk8("stat_full_const", m_status(), 8'h42);
      for (int i = 0; i < 5; i++) idle_cycle("tx_drain", 1'b1, 1'b0, 8'h00);

      // RX overrun and W1C clear
      idle_cycle("rx_a5", 1'b0, 1'b1, 8'hA5);
      idle_cycle("rx_3c", 1'b0, 1'b1, 8'h3C);
      xfer("stat_ovr", 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
      xfer("rx_rd", 1'b0, 8'h03, 8'h00, 1'b0, 8'h00, 1'b0);
      xfer("w1c", 1'b1, 8'h01, 8'h08, 1'b0, 8'h00, 1'b0);
      xfer("stat_clr", 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0);

      // Error cases
      xfer("rx_empty_rd", 1'b0, 8'h03, 8'h00, 1'b0, 8'h00, 1'b0);
      xfer("unmapped_wr", 1'b1, 8'h07, 8'hFF, 1'b0, 8'h00, 1'b0);
      xfer("tx_rd", 1'b0, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0);
      xfer("rx_wr", 1'b1, 8'h03, 8'h12, 1'b0, 8'h00, 1'b0);
      xfer("stat_err", 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0);

      // RX read racing a new strobe
      idle_cycle("rx_77", 1'b0, 1'b1, 8'h77);
      xfer("rx_race", 1'b0, 8'h03, 8'h00, 1'b1, 8'h88, 1'b0);
      xfer("stat_race", 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
      xfer("rx_race2", 1'b0, 8'h03, 8'h00, 1'b0, 8'h00, 1'b0);

      // Overrun event beats W1C clear
      idle_cycle("rx_01", 1'b0, 1'b1, 8'h01);
      idle_cycle("rx_02", 1'b0, 1'b1, 8'h02);
      xfer("w1c_race", 1'b1, 8'h01, 8'h08, 1'b1, 8'h03, 1'b0);
      xfer("stat_w1c_race", 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0);

      // Push into full FIFO refused even with same-cycle pop; push+pop keeps count
      for (int i = 0; i < 4; i++)
         xfer("tx_fill2", 1'b1, 8'h02, 8'h20 + 8'(i), 1'b0, 8'h00, 1'b0);
      xfer("push_full_pop", 1'b1, 8'h02, 8'h30, 1'b0, 8'h00, 1'b1);
      xfer("push_pop", 1'b1, 8'h02, 8'h31, 1'b0, 8'h00, 1'b1);
      xfer("stat_pp", 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0);

      // Abort by dropping psel
      abort_xfer("abort", 8'h00, 8'hC3);

      // Reset in the middle of a CTRL write
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h99;
      @(posedge pclk); #1;
      penable = 1'b1;
      #1 presetn = 1'b0;
      #1 chk_reset_outs("rst_mid");
      psel = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      presetn = 1'b1;
      m_reset();
      @(posedge pclk); #1;
      chk_outs("after_rst");
      xfer("post_rst_wr", 1'b1, 8'h00, 8'h3C, 1'b0, 8'h00, 1'b0);
      xfer("post_rst_rd", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 9);
         b   = 8'($urandom);
         if (sel < 7) begin
            a   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255))
                                              : 8'($urandom_range(0, 3));
            wr  = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            crx = ($urandom_range(0, 3) == 0);
            ctx = ($urandom_range(0, 3) == 0);
            xfer("rnd_xfer", wr, a, d, crx, b, ctx);
         end else if (sel < 9) begin
            idle_cycle("rnd_idle", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b);
         end else begin
            abort_xfer("rnd_abort", 8'($urandom_range(0, 3)), b);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_completer.md
APB_COMPLETER -- requirements
Module: apb_completer

Interface
REQ-001 Parameter WAIT_STATES, default 1, meaning the number of wait cycles inserted before pready in each access (range 0-7).
REQ-002 Parameter FIFO_DEPTH, default 4, meaning the TX FIFO depth in entries (power of two).
REQ-003 pclk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 presetn  input  1  reset; asynchronous, active-low.
REQ-005 psel, penable, pwrite  input  1 each  APB requester controls.
REQ-006 paddr  input  8  byte address; pwdata  input  8  write data.
REQ-007 prdata  output  8  read data; pready  output  1  transfer complete; pslverr  output  1  transfer error.
REQ-008 ctrl_out  output  8  current CTRL register value.
REQ-009 tx_data  output  8 / tx_valid  output  1 / tx_ready  input  1  TX stream to the I2C engine, valid/ready handshake.
REQ-010 rx_data  input  8 / rx_valid  input  1  single-cycle RX byte strobe from the I2C engine (no backpressure).

Function
REQ-011 FSM states IDLE and ACCESS; IDLE->ACCESS on psel&!penable, loading wait counter with WAIT_STATES.
REQ-012 In ACCESS: counter decrements while nonzero; pready = (state==ACCESS)&&(counter==0), combinational from registered state.
REQ-013 Completion cycle = psel&penable&pready; it SHALL commit the operation and return FSM to IDLE.
REQ-014 psel deasserted in ACCESS before completion SHALL return to IDLE with no register/FIFO side effect.
REQ-015 Register map: 0x00 CTRL rw; 0x01 STATUS (bit3 W1C, other bits ignored on write); 0x02 TXDATA write-only; 0x03 RXDATA read-only; all other addresses unmapped.
REQ-016 STATUS = {1'b0, tx_count[2:0], overrun, rx_full, tx_full, tx_empty} (bits 7..0).
REQ-017 prdata SHALL equal the addressed value in the completion cycle and 8'h00 in all other cycles; TXDATA reads return 8'h00.
REQ-018 pslverr SHALL be 1 only in a completion cycle, for: unmapped address, write to RXDATA, read of TXDATA, TXDATA write while FIFO full, RXDATA read while rx_full=0; erroring transfers SHALL have no side effect.
REQ-019 TXDATA write pushes pwdata into FIFO; tx_valid = !empty, tx_data = head entry; pop on tx_valid&tx_ready.
REQ-020 Full/empty are evaluated before same-cycle pop/push: push when full is refused (pslverr) even if a pop occurs that cycle; simultaneous push and pop on non-full, non-empty FIFO keeps count unchanged.
REQ-021 FIFO pointers wrap modulo FIFO_DEPTH; tx_count range 0..FIFO_DEPTH.
REQ-022 rx_valid with rx_full=0 captures rx_data and sets rx_full; rx_valid with rx_full=1 drops the byte and sets sticky overrun.
REQ-023 RXDATA read completion clears rx_full; same-cycle rx_valid SHALL capture new byte, leave rx_full=1, and the read returns the old byte with no overrun.
REQ-024 STATUS write with pwdata[3]=1 clears overrun; simultaneous overrun event wins (overrun stays 1).

Reset
REQ-025 presetn low SHALL immediately force: state IDLE, counter 0, CTRL 0, FIFO empty, rx_full 0, overrun 0.
REQ-026 During reset: prdata=0, pready=0, pslverr=0, ctrl_out=0, tx_valid=0, tx_data=0; reset mid-transfer aborts it with no commit.

Structure
REQ-027 Package apb_completer_pkg SHALL hold register address constants, the FSM state enum, and STATUS bit index constants.
REQ-028 TX buffering SHALL be a sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count).

Verification
REQ-029 WAIT_STATES=1: write 0x5A to 0x00 -> pready high exactly 1 cycle after first ACCESS cycle, pslverr=0, ctrl_out=0x5A; read 0x00 -> prdata=0x5A.
REQ-030 Five TXDATA writes 0x11..0x15 with tx_ready=0 -> first four OK, fifth pslverr=1, STATUS=0x42; then tx_ready=1 -> tx_data 0x11..0x14 in order, tx_valid drops.
REQ-031 rx_valid with 0xA5, then 0x3C -> read RXDATA returns 0xA5, STATUS bit3=1; write STATUS 0x08 -> overrun cleared.
REQ-032 Read 0x03 with rx_full=0 and write to 0x07 -> both pslverr=1, prdata=0, no state change.
REQ-033 presetn asserted in ACCESS of a CTRL write -> ctrl_out stays 0, FSM IDLE, next transfer completes normally.
